// File: rtl/mult_sched_pkg.sv
// Shared types for the multiplier issue scheduler.
//   req_id_e   : requester identifier (0 or 1)
//   tag_t      : in-flight tag carried alongside the datapath {vld, id}
//   pick_grant : round-robin choice between the two requesters
package mult_sched_pkg;

  localparam int unsigned ID_W = 1;

  typedef enum logic [ID_W-1:0] {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    vld;
    req_id_e id;
  } tag_t;

  // A lone valid requester wins; on contention the one not served last wins.
  function automatic req_id_e pick_grant(input logic v0, input logic v1, input req_id_e last);
    if (v0 && v1) begin
      return (last == REQ0) ? REQ1 : REQ0;
    end else if (v1) begin
      return REQ1;
    end else begin
      return REQ0;
    end
  endfunction

endpackage

// File: rtl/mult_sched_fifo.sv
// First-word-fall-through FIFO for scheduler responses.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  : push; accepted when not full, or when full and popping
//   rd_en           : pop the head entry (ignored when empty)
//   rd_data         : head entry, valid whenever empty=0
//   full, empty     : occupancy flags
module mult_sched_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_rd_c, do_wr_c;

  // Pointer advance with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_rd_c  = rd_en && !empty;
    do_wr_c  = wr_en && (!full || do_rd_c);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr_c) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_rd_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_wr_c && !do_rd_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_wr_c && do_rd_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    cnt_q    <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && full && !do_rd_c))
        else $error("mult_sched_fifo: write while full");
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Fixed-depth register pipeline; a value presented on d appears on q PIP_D
// cycles later. Synchronous reset clears every stage.
//   clk, rst : clock, synchronous active-high reset
//   d        : stage-0 input (REG_W bits)
//   q        : last-stage output (REG_W bits)
module pipe_reg #(
  parameter int unsigned REG_W = 1,
  parameter int unsigned PIP_D = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] d,
  output logic [REG_W-1:0] q
);

  logic [REG_W-1:0] stage_q [PIP_D];
  logic [REG_W-1:0] stage_d [PIP_D];

  // Shift by one stage per cycle.
  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < PIP_D; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (rst) begin
      for (int unsigned i = 0; i < PIP_D; i++) begin
        stage_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign q = stage_q[PIP_D-1];

endmodule

// File: rtl/mult_sched.sv
// Two-requester issue scheduler for a fixed-latency pipelined multiplier.
// Round-robin arbitration, credit-guarded launch, tag pipe tracking in-flight
// operations, and a FWFT response FIFO that absorbs back-pressure.
//   clk, rst                         : clock, synchronous active-high reset
//   reqN_valid/ready, reqN_a/b       : requester N operand handshake
//   dp_valid, dp_a, dp_b             : launch into the multiplier
//   dp_p                             : product, LAT cycles after launch
//   resp_valid/ready, resp_p/resp_id : response handshake, launch order
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned LAT    = 3,
  parameter int unsigned FIFO_D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           dp_valid,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  input  logic [2*W-1:0] dp_p,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [2*W-1:0] resp_p,
  output logic           resp_id
);

  localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);
  localparam int unsigned RESP_W = 2 * W + 1;

  logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;
  req_id_e           last_grant_q, last_grant_d;
  req_id_e           grant_c;
  logic              can_launch_c, accept_c, pop_c;
  tag_t              tag_in_c, tag_out;
  logic              fifo_full, fifo_empty;
  logic [RESP_W-1:0] fifo_wdata, fifo_rdata;

  assign resp_valid = !rst && !fifo_empty;
  assign pop_c      = resp_valid && resp_ready;

  // Arbitration and launch qualification; a pop frees a slot this same cycle.
  always_comb begin
    grant_c      = pick_grant(req0_valid, req1_valid, last_grant_q);
    can_launch_c = !rst && ((credit_cnt_q != '0) || pop_c);
    accept_c     = can_launch_c && ((grant_c == REQ1) ? req1_valid : req0_valid);
  end

  assign req0_ready = can_launch_c && (grant_c == REQ0);
  assign req1_ready = can_launch_c && (grant_c == REQ1);
  assign dp_valid   = accept_c;
  assign dp_a       = accept_c ? ((grant_c == REQ1) ? req1_a : req0_a) : '0;
  assign dp_b       = accept_c ? ((grant_c == REQ1) ? req1_b : req0_b) : '0;

  always_comb begin
    tag_in_c.vld = accept_c;
    tag_in_c.id  = grant_c;
  end

  // Credits count FIFO slots not yet claimed by in-flight or stored results.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    last_grant_d = last_grant_q;
    if (accept_c && !pop_c) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end else if (!accept_c && pop_c) begin
      credit_cnt_d = credit_cnt_q + CNT_W'(1);
    end
    if (accept_c) begin
      last_grant_d = grant_c;
    end
    if (rst) begin
      credit_cnt_d = CNT_W'(FIFO_D);
      last_grant_d = REQ1;
    end
  end

  always_ff @(posedge clk) begin
    credit_cnt_q <= credit_cnt_d;
    last_grant_q <= last_grant_d;
  end

  pipe_reg #(
    .REG_W ($bits(tag_t)),
    .PIP_D (LAT)
  ) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .d   (tag_in_c),
    .q   (tag_out)
  );

  assign fifo_wdata = {dp_p, tag_out.id};

  mult_sched_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_out.vld),
    .wr_data (fifo_wdata),
    .rd_en   (pop_c),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign resp_p  = fifo_rdata[RESP_W-1:1];
  assign resp_id = fifo_rdata[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (credit_cnt_q <= CNT_W'(FIFO_D))
        else $error("mult_sched: credit count above depth");
      assert (!(accept_c && !pop_c && (credit_cnt_q == '0)))
        else $error("mult_sched: credit underflow");
      assert (!(tag_out.vld && fifo_full && !pop_c))
        else $error("mult_sched: response overflow");
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched with a behavioural multiplier and a response
// scoreboard checking every launch and every returned product.
module tb_mult_sched;

  localparam int unsigned W      = 16;
  localparam int unsigned LAT    = 3;
  localparam int unsigned FIFO_D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           dp_valid;
  logic [W-1:0]   dp_a, dp_b;
  logic [2*W-1:0] dp_p;
  logic           resp_valid, resp_ready, resp_id;
  logic [2*W-1:0] resp_p;

  always #5 clk = ~clk;

  mult_sched #(.W(W), .LAT(LAT), .FIFO_D(FIFO_D)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .dp_valid   (dp_valid),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_p       (dp_p),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_p     (resp_p),
    .resp_id    (resp_id)
  );

  // Behavioural multiplier: product captured mid-cycle, LAT-stage pipe.
  logic [2*W-1:0] launch_prod;
  logic [2*W-1:0] mpipe [LAT];
  always @(negedge clk) launch_prod = dp_valid ? (2*W)'(dp_a) * (2*W)'(dp_b) : '0;
  always @(posedge clk) begin
    mpipe[0] <= launch_prod;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign dp_p = mpipe[LAT-1];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected {product, id} queued at launch, compared at pop.
  logic [2*W:0]   sb_q [$];
  logic [2*W:0]   sb_exp;
  logic           mon_id;
  logic [W-1:0]   mon_a, mon_b;
  logic           hold_v = 1'b0;
  logic [2*W:0]   hold_data;
  int             acc_cnt = 0;
  int             pop_cnt = 0;
  int             flush_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      flush_cnt += sb_q.size();
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (dp_valid) begin
        mon_id = req1_valid && req1_ready;
        chk("launch_handshake", (req0_valid & req0_ready) | (req1_valid & req1_ready), 1);
        mon_a = mon_id ? req1_a : req0_a;
        mon_b = mon_id ? req1_b : req0_b;
        chk("dp_a", dp_a, mon_a);
        chk("dp_b", dp_b, mon_b);
        sb_q.push_back({(2*W)'(mon_a) * (2*W)'(mon_b), mon_id});
        acc_cnt++;
      end else begin
        chk("dp_idle_zero", {dp_a, dp_b}, 0);
      end
      if (hold_v && resp_valid) chk("resp_stable", {resp_p, resp_id}, hold_data);
      hold_v    = resp_valid && !resp_ready;
      hold_data = {resp_p, resp_id};
      if (resp_valid && resp_ready) begin
        pop_cnt++;
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("resp_p", resp_p, sb_exp[2*W:1]);
          chk("resp_id", resp_id, sb_exp[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int base;
  int nacc;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 16'd1; req0_b = 16'd2; req1_a = 16'd3; req1_b = 16'd4;
    resp_ready = 1'b1;

    // Reset: nothing offered or launched even with both requesters valid.
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_resp_valid", resp_valid, 0);
    step();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_credit", dut.credit_cnt_q, FIFO_D);
    chk("idle_dp_valid", dp_valid, 0);

    // Single op 3*5: launch in cycle 0, response in cycle LAT+1.
    step();
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
    @(negedge clk);
    chk("t1_dp_valid", dp_valid, 1);
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_dp_a", dp_a, 3);
    chk("t1_dp_b", dp_b, 5);
    for (int i = 1; i <= 4; i++) begin
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("t1_resp_valid", resp_valid, (i == 4));
    end
    chk("t1_resp_p", resp_p, 15);
    chk("t1_resp_id", resp_id, 0);

    // Both valid: grants alternate, starting with req1 since req0 went last.
    for (int i = 0; i < 8; i++) begin
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 16'(100 + i); req0_b = 16'd2;
      req1_a = 16'(200 + i); req1_b = 16'd3;
      @(negedge clk);
      chk("t2_dp_valid", dp_valid, 1);
      chk("t2_grant_req1", req1_ready, (i % 2 == 0));
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) step();
    chk("t2_drained", sb_q.size(), 0);

    // Back-pressure: exactly FIFO_D accepts, then one more per pop.
    base = acc_cnt;
    resp_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req0_valid = 1'b1; req0_a = 16'(7 + i); req0_b = 16'd9;
      step();
    end
    @(negedge clk);
    chk("t3_accepts", acc_cnt - base, 4);
    chk("t3_ready_low", req0_ready, 0);
    chk("t3_resp_valid", resp_valid, 1);
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t3_bypass_ready", req0_ready, 1);
    chk("t3_bypass_launch", dp_valid, 1);
    step();
    resp_ready = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("t3_one_more", acc_cnt - base, 5);
    chk("t3_ready_low2", req0_ready, 0);
    step();
    req0_valid = 1'b0; resp_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("t3_drained", sb_q.size(), 0);
    chk("t3_resp_idle", resp_valid, 0);

    // Sustained throughput: 100 launches in 100 consecutive cycles.
    base = acc_cnt;
    nacc = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      req0_valid = 1'b1; req0_a = 16'(i * 37 + 1); req0_b = 16'(i + 3);
      @(negedge clk);
      if (dp_valid) nacc++;
    end
    chk("t4_consecutive", nacc, 100);
    step();
    req0_valid = 1'b0;
    repeat (10) step();
    chk("t4_drained", sb_q.size(), 0);
    chk("t4_accepts", acc_cnt - base, 100);

    // Reset with one result stored and two in flight.
    step();                                  // c0
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd11; req0_b = 16'd13;
    step(); req0_valid = 1'b0;               // c1
    step();                                  // c2
    step(); req0_valid = 1'b1; req0_a = 16'd17; req0_b = 16'd19;   // c3
    step(); req0_a = 16'd23; req0_b = 16'd29;                      // c4
    @(negedge clk);
    chk("t5_resp_valid_pre", resp_valid, 1);
    chk("t5_credit_pre", dut.credit_cnt_q, 2);
    step();                                  // c5: reset
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 16'd41; req0_b = 16'd43;
    req1_valid = 1'b1; req1_a = 16'd51; req1_b = 16'd53;
    @(negedge clk);
    chk("t5_rst_resp_valid", resp_valid, 0);
    chk("t5_rst_req0_ready", req0_ready, 0);
    chk("t5_rst_req1_ready", req1_ready, 0);
    chk("t5_rst_dp_valid", dp_valid, 0);
    step();                                  // c6
    rst = 1'b0;
    @(negedge clk);
    chk("t5_credit_post", dut.credit_cnt_q, FIFO_D);
    chk("t5_resp_valid_post", resp_valid, 0);
    chk("t5_first_grant_req0", req0_ready, 1);
    chk("t5_first_dp_a", dp_a, 41);
    step();                                  // c7
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      @(negedge clk);
      chk("t5_no_stale", resp_valid, (i == 10));
      if (i < 10) step();
    end
    chk("t5_resp_p", resp_p, 1763);
    chk("t5_resp_id", resp_id, 0);
    repeat (4) step();
    chk("t5_drained", sb_q.size(), 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("t6_drained", sb_q.size(), 0);
    chk("t6_resp_idle", resp_valid, 0);
    chk("t6_credit_restored", dut.credit_cnt_q, FIFO_D);
    chk("t6_conserve", acc_cnt, pop_cnt + flush_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Two-requester issue scheduler for the fixed-latency pipelined multiplier datapath. It arbitrates operand pairs from two valid/ready requesters round-robin and launches at most one per cycle into the multiplier. A tag pipeline tracks in-flight operations, and a credit-guarded output FIFO captures results, so back-pressure never drops data even though the datapath cannot stall.

## Interface
Parameters:
- W, 16, operand width; product width is 2*W
- LAT, 3, datapath latency in cycles (≥1); operands launched in cycle T return on dp_p in cycle T+LAT
- FIFO_D, 4, response FIFO depth (≥1); full throughput requires FIFO_D ≥ LAT+1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  W  requester 0 operands
- req1_valid, req1_ready, req1_a, req1_b  as above, requester 1
- dp_valid  out  1  launch this cycle
- dp_a, dp_b  out  W  operands to multiplier; 0 when dp_valid=0
- dp_p  in  2*W  multiplier product, LAT cycles after launch
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_p  out  2*W  product
- resp_id  out  1  originating requester

## Operation
- Credits: credit_cnt, reset to FIFO_D. It counts FIFO slots not yet claimed by in-flight or stored results.
  - Decrements on launch; increments on pop (resp_valid & resp_ready).
  - Both in one cycle: unchanged.
- can_launch = !rst & (credit_cnt != 0 | pop).
  - Pop bypass: a full FIFO being popped still permits a launch in the same cycle.
- Arbitration: 1-bit last_grant pointer, reset 1 so requester 0 wins first.
  - One valid requester: it is granted.
  - Both valid: the requester ≠ last_grant is granted.
  - last_grant updates only on an actual accept.
- reqN_ready = can_launch & grant==N. Ready may depend on valids; valid must not depend on ready (requester obligation).
- Launch = accept. In the same cycle:
  - dp_valid=1, dp_a/dp_b = granted operands (combinational mux);
  - {1'b1, id} is pushed into the tag pipe, a pipe_reg instance with REG_W=2, PIP_D=LAT.
- Tag pipe output valid in cycle T+LAT: {dp_p, id} is written to the FIFO at the end of that cycle. Credits guarantee the FIFO is never full at write time; overflow is an assertion failure.
- FIFO: first-word-fall-through.
  - resp_valid = !empty; resp_p/resp_id come from the head entry.
  - Simultaneous write and pop are permitted when full or empty.
- Reset (including mid-operation):
  - tag pipe cleared and FIFO emptied, so in-flight results arriving later are discarded;
  - credit_cnt = FIFO_D, last_grant = 1;
  - resp_valid = 0, req0_ready = req1_ready = 0, dp_valid = 0, dp_a = dp_b = 0 during and after reset until a launch.

## Timing
- Launch to FIFO write: LAT cycles. Launch to resp_valid with an empty FIFO: LAT+1 cycles.
- Throughput: 1 launch/cycle sustained when resp_ready=1 and FIFO_D ≥ LAT+1. With smaller FIFO_D, throughput is FIFO_D launches per LAT+1 cycles.
- resp_p/resp_id are stable while resp_valid=1 & resp_ready=0.
- Responses are returned in launch order, interleaved across requesters.
- credit_cnt width: $clog2(FIFO_D+1). It never exceeds FIFO_D and never underflows (assert both).

## Structure
- Shared package entry: none required. CNT_W and PTR_W are localparams.
- Reuse the existing pipe_reg as the tag pipe.
- One natural sub-module: mult_sched_fifo, a parameterised FWFT FIFO with width 2*W+1 and depth FIFO_D, with full/empty flags.
- The arbiter and credit counter stay inline.

## Test plan
- Single op, LAT=3, FIFO_D=4, resp_ready=1: req0 a=3, b=5 at cycle 0 → dp_valid at cycle 0; resp_valid at cycle 4 with resp_p=15, resp_id=0.
- Both requesters valid continuously → grants alternate 0,1,0,1…, one dp_valid per cycle; responses alternate resp_id in order.
- resp_ready=0 with req0 always valid, FIFO_D=4 → exactly 4 accepts, then req0_ready=0. Raising resp_ready for one cycle yields exactly one new accept, in the same pop cycle.
- FIFO_D=LAT+1, resp_ready=1, 100 ops → 100 accepts in 100 consecutive cycles, no overflow, products correct.
- Assert rst with 2 ops in flight and 1 in the FIFO → next cycle resp_valid=0 and credit_cnt=4. Stale dp_p results are never presented; the first post-reset grant goes to req0.
- Random valid/ready on all ports against a scoreboard → every product matches a*b with the correct id, with no loss or duplication.
